divserial: RTL
==============

Name: divserial

Overview:
- Iterative radix-2 restoring divider; the inverse companion of the serial multiplier in the execute-stage multiply/divide unit.
- Accepts a one-cycle start pulse with dividend and divisor and produces one quotient bit per cycle.
- Presents quotient and remainder with a valid flag that stays asserted until the next start or reset.
- Supports signed (truncate toward zero) and unsigned division.

Parameters:
- WIDTH, 32, operand/quotient/remainder width in bits.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  reset, synchronous, active-high.
- DST  input  1  start pulse; operands sampled on the same edge.
- DSGN  input  1  1 = signed division, 0 = unsigned; sampled with DST.
- SRCA  input  WIDTH  dividend.
- SRCB  input  WIDTH  divisor.
- QUOT  output  WIDTH  quotient (registered).
- REM  output  WIDTH  remainder (registered).
- DIVV  output  1  result valid (registered).
- BUSY  output  1  high while in CALC or SIGN.

Behaviour:
- States: IDLE, CALC, SIGN, DONE.
- RST (sampled on an edge) has priority over everything: next state IDLE; QUOT=0, REM=0, DIVV=0, BUSY=0, internal regs cleared. Applies mid-operation; no partial result is ever flagged valid.
- Accept: DST=1 while in IDLE or DONE with RST=0.
  - Latch dsgn, the original SRCA, and a zero-divisor flag.
  - Latch |SRCA| and |SRCB| if DSGN=1, raw values otherwise.
  - Latch neg_q = sign(A) XOR sign(B) and neg_r = sign(A), both only when DSGN=1.
  - Clear partial remainder, count=0, DIVV<=0, next state CALC.
- DST in CALC or SIGN is ignored and does not queue. Operands may change after acceptance.
- CALC, one step per cycle:
  - Shift {rem, dividend} left by 1.
  - Trial = rem_shifted - divisor, computed WIDTH+1 bits wide.
  - If trial is non-negative, rem <= trial and shift in quotient bit 1; else keep rem_shifted and shift in 0.
  - After WIDTH steps (count == WIDTH-1), next state SIGN.
- SIGN, one cycle:
  - QUOT <= neg_q ? -q : q.
  - REM <= neg_r ? -r : r.
  - Zero-divisor override: QUOT = all ones, REM = original SRCA, for both signed and unsigned.
  - DIVV<=1, next state DONE.
- DONE: outputs held, DIVV=1. A new accept drops DIVV on the next edge.
- Latency is fixed regardless of operand values.
  - Accept edge is edge 0; CALC occupies edges 1..WIDTH; SIGN is edge WIDTH+1.
  - DIVV is high after edge WIDTH+1 (33 for WIDTH=32).
  - Back-to-back throughput is one result per WIDTH+2 cycles.
- Signed overflow (MIN / -1): |MIN| = 0x80000000 as unsigned, so QUOT=0x80000000, REM=0. Falls out naturally; no special case.
- Widths: remainder datapath is WIDTH+1 bits; the count register is clog2(WIDTH)+1 bits.
- Invariant for every non-zero divisor: A == Q*B + R, with |R| < |B| and R taking the sign of A (signed) or R < B (unsigned).

Decomposition:
- Shared package div_pkg: state encoding (IDLE=0, CALC=1, SIGN=2, DONE=3), default WIDTH, and the zero-divisor constants (QUOT_DIV0 = all ones).
- One natural combinational sub-module, divstep: inputs rem, dividend MSB, and divisor; outputs next rem and the quotient bit. Reusable if a radix-4 variant instantiates two.

Test Plan:
- Unsigned 100/7, DSGN=0 -> after 33 edges DIVV=1, QUOT=14, REM=2; DIVV stays high while DST stays low.
- Signed -7/2 (SRCA=0xFFFFFFF9, SRCB=2) -> QUOT=0xFFFFFFFD, REM=0xFFFFFFFF. Signed 7/-2 -> QUOT=0xFFFFFFFD, REM=1.
- Divide by zero, SRCA=0x00001234, SRCB=0, both DSGN values -> QUOT=0xFFFFFFFF, REM=0x00001234 at the same 33-cycle latency.
- SRCA=0x80000000, SRCB=0xFFFFFFFF:
  - DSGN=1 -> QUOT=0x80000000, REM=0.
  - DSGN=0 -> QUOT=0, REM=0x80000000.
- Second DST pulse at cycle 5 with different operands -> ignored; first result delivered unchanged at cycle 33, BUSY high for cycles 1..33.
- Two further cases:
  - RST at cycle 10 of a division -> next edge QUOT=0, REM=0, DIVV=0, IDLE; a fresh DST afterwards yields a correct result 33 cycles later.
  - DST in DONE -> DIVV low the next cycle, new result valid 33 edges after that accept.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the serial divider: FSM encoding,
// default width and the divide-by-zero result constant.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int DIV_WIDTH = 32;

  // Sliced down to the instance width by the user.
  localparam logic [63:0] QUOT_DIV0 = '1;

endpackage

// File: rtl/divstep.sv
// One restoring-division step: shift in a dividend bit, trial-subtract.
// Ports: rem/msb/divisor in; rem_next/qbit out. Purely combinational.
module divstep
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             qbit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem < divisor always holds, so WIDTH+1 bits cannot overflow
  // and trial[WIDTH] is a valid sign bit.
  assign shifted  = {rem, msb};
  assign trial    = shifted - {1'b0, divisor};
  assign qbit     = ~trial[WIDTH];
  assign rem_next = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/divserial.sv
// Iterative radix-2 restoring divider, signed or unsigned.
// Ports: CLK/RST, DST start, DSGN, SRCA/SRCB in; QUOT/REM/DIVV/BUSY out.
module divserial
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             DST,
  input  logic             DSGN,
  input  logic [WIDTH-1:0] SRCA,
  input  logic [WIDTH-1:0] SRCB,
  output logic [WIDTH-1:0] QUOT,
  output logic [WIDTH-1:0] REM,
  output logic             DIVV,
  output logic             BUSY
);

  localparam int CW = $clog2(WIDTH) + 1;

  div_state_t state, state_nx;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] a_orig;
  logic             dsgn;
  logic             div0;
  logic             neg_q;
  logic             neg_r;

  logic             accept;
  logic             last;
  logic [WIDTH-1:0] rem_step;
  logic             qbit;
  logic             sa;
  logic             sb;

  assign accept = DST && (state == IDLE || state == DONE);
  assign last   = (count == CW'(WIDTH - 1));
  assign sa     = DSGN & SRCA[WIDTH-1];
  assign sb     = DSGN & SRCB[WIDTH-1];
  assign BUSY   = (state == CALC) || (state == SIGN);

  divstep #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .msb     (dvd[WIDTH-1]),
    .divisor (dvs),
    .rem_next(rem_step),
    .qbit    (qbit)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: if (accept) state_nx = CALC;
      CALC:       if (last)   state_nx = SIGN;
      SIGN:       state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count  <= '0;
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      a_orig <= '0;
      dsgn   <= 1'b0;
      div0   <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      QUOT   <= '0;
      REM    <= '0;
      DIVV   <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            dsgn   <= DSGN;
            a_orig <= SRCA;
            div0   <= (SRCB == '0);
            dvd    <= sa ? -SRCA : SRCA;
            dvs    <= sb ? -SRCB : SRCB;
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            rem    <= '0;
            count  <= '0;
            DIVV   <= 1'b0;
          end
        end
        CALC: begin
          rem   <= rem_step;
          dvd   <= {dvd[WIDTH-2:0], qbit};
          count <= count + 1'b1;
        end
        SIGN: begin
          if (div0) begin
            QUOT <= QUOT_DIV0[WIDTH-1:0];
            REM  <= a_orig;
          end else begin
            QUOT <= (dsgn & neg_q) ? -dvd : dvd;
            REM  <= (dsgn & neg_r) ? -rem : rem;
          end
          DIVV <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
